music_player: RTL and testbench
===============================

Name: music_player

Overview:
- Parametrised multi-channel tune sequencer for the lab audio path.
- A tempo divider advances a beat index through a song ROM.
- Per-channel tone frequencies are registered and driven to the PWM note generators, which sit downstream.
- Adds start/pause/stop/loop control, runtime tempo and song selection, and automatic articulation gaps between repeated notes. Previously, silences for repeated notes were hard-coded into the song tables.

Parameters:
- NUM_CH, 2, number of tone channels; channel 0 is the melody.
- BEAT_W, 12, width of the beat index.
- SONG_LEN, 128, entries per song; must be ≤ 2**BEAT_W.
- NUM_SONGS, 2, number of selectable songs.
- DIV_W, 24, width of the tempo divider.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin playback from beat 0; level, acted on in IDLE only.
- pause  in  1  level; while high, playback is frozen.
- stop  in  1  abort to IDLE.
- loop_en  in  1  wrap at end of song instead of finishing; sampled at start.
- song_sel  in  $clog2(NUM_SONGS)  song index; sampled at start.
- tempo_div  in  DIV_W  clk cycles per beat entry; 0 is treated as 1.
- tone  out  NUM_CH*32  per-channel frequency in Hz; channel c occupies bits [32c+31:32c].
- cur_note  out  4  scale degree of channel 0: C=1 … B=7, 10 = none or silence.
- beat_num  out  BEAT_W  current beat index.
- playing  out  1  high in PLAY.
- done  out  1  one-cycle pulse at non-looping song end.

Behaviour:
- Reset state: state=IDLE, beat_num=0, tick counter=0, every tone channel=SIL (50_000_000), cur_note=10, playing=0, done=0.
- FSM states: IDLE, PLAY, PAUSE.
- IDLE:
  - start=1 and stop=0 → PLAY next cycle.
  - On entry, latch song_sel and loop_en, clear beat_num and the tick counter.
- PLAY:
  - Tick counter counts 0 … max(tempo_div,1)-1; at the terminal count it clears and asserts an internal tick.
  - A tempo_div change takes effect on the next compare.
  - On tick with beat_num < SONG_LEN-1: beat_num+1.
  - On tick with beat_num = SONG_LEN-1 and loop latched: beat_num ← 0, no done.
  - On tick with beat_num = SONG_LEN-1 and no loop: → IDLE, beat_num ← 0, done=1 for one cycle.
  - pause=1 → PAUSE.
- PAUSE:
  - Tick counter and beat_num hold; all tones output SIL.
  - pause=0 → PLAY; the remaining ticks of the current entry complete.
- stop=1 in any state → IDLE next cycle with beat_num=0. stop beats start, pause and tick when simultaneous.
- start while in PLAY or PAUSE is ignored.
- Song ROM:
  - Each entry per channel is {freq[31:0], onset}; onset=1 marks the first entry of a note.
  - The ROM is read at beat_num and at beat_num+1 (lookahead). The lookahead index wraps to 0 only when loop is latched; otherwise the next entry is SIL.
- Articulation rule: channel c outputs SIL for the current entry when the next entry has onset=1 and the same freq as the current entry.
- Output timing:
  - tone is registered and updates one cycle after beat_num changes.
  - tone is SIL in IDLE and PAUSE.
- cur_note is combinational on the registered tone of channel 0.
  - Frequencies 524/588/660/698/784/880/988 and 262/294/330/349/392/440/494 map to 1–7 respectively.
  - Anything else maps to 10.
- Async reset mid-play: immediate return to reset values, and no done pulse.
- SONG_LEN not a power of two: the wrap is by compare, never by overflow.

Decomposition:
- Package music_pkg:
  - note frequency constants (C3–B3, C4–B4, SIL);
  - state enum;
  - ROM entry struct {freq, onset};
  - function freq_to_note() returning 4 bits.
- Sub-module music_song_rom:
  - purely combinational, two read ports (index, index+1);
  - parameters NUM_CH, SONG_LEN, NUM_SONGS.
  - Song 0:
    - melody G E E F D D C D E F G G G (half/one-beat notes, 8 entries per half beat);
    - bass C G B C G B.
  - Song 1: counter-melody.
- Player FSM, tempo divider, articulation logic and output registers stay in music_player.

Test Plan:
- Reset held low, then released → all tone channels=50_000_000, beat_num=0, cur_note=10, playing=0, done=0.
- start=1, song_sel=0, tempo_div=4 → beat_num increments every 4 cycles; one cycle after beat 0 is entered, ch0=784, ch1=524, cur_note=5.
- Song 0 at beat 15 (ch0 E at 660, onset at 16 with E) → ch0=SIL for beat 15 only; 660 again at beat 16.
- pause=1 for 20 cycles at beat 10, two ticks in → beat_num stays 10, tones=SIL; after release, beat 11 arrives exactly 2 cycles later.
- Non-looping play to beat 127, then tick → done high for exactly 1 cycle, IDLE, beat_num=0. With loop_en=1 at start: beat_num 127→0, done stays 0, playing stays 1.
- In PLAY at beat 50, start=stop=1 in the same cycle → IDLE, beat_num=0, tones=SIL. Assert rst_n=0 asynchronously mid-tick at beat 30 → outputs reset within the same cycle, no done.

Source files
------------

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - note constants, player states and song ROM entry type
package music_pkg;

    localparam logic [31:0] C3  = 32'd262;
    localparam logic [31:0] D3  = 32'd294;
    localparam logic [31:0] E3  = 32'd330;
    localparam logic [31:0] F3  = 32'd349;
    localparam logic [31:0] G3  = 32'd392;
    localparam logic [31:0] A3  = 32'd440;
    localparam logic [31:0] B3  = 32'd494;
    localparam logic [31:0] C4  = 32'd524;
    localparam logic [31:0] D4  = 32'd588;
    localparam logic [31:0] E4  = 32'd660;
    localparam logic [31:0] F4  = 32'd698;
    localparam logic [31:0] G4  = 32'd784;
    localparam logic [31:0] A4  = 32'd880;
    localparam logic [31:0] B4  = 32'd988;
    localparam logic [31:0] SIL = 32'd50_000_000;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    typedef struct packed {
        logic [31:0] freq;
        logic        onset;
    } rom_entry_t;

    function automatic logic [3:0] freq_to_note(input logic [31:0] freq);
        case (freq)
            C3, C4:  return 4'd1;
            D3, D4:  return 4'd2;
            E3, E4:  return 4'd3;
            F3, F4:  return 4'd4;
            G3, G4:  return 4'd5;
            A3, A4:  return 4'd6;
            B3, B4:  return 4'd7;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/music_song_rom.sv
// rtl/music_song_rom.sv - combinational two-port song table (current and lookahead entry)
module music_song_rom
    import music_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int SONG_LEN  = 128,
    parameter int NUM_SONGS = 2,
    parameter int BEAT_W    = 12,
    parameter int SEL_W     = 1
) (
    input  logic [SEL_W-1:0]             song,
    input  logic [BEAT_W-1:0]            cur_idx,
    input  logic [BEAT_W-1:0]            nxt_idx,
    output rom_entry_t [NUM_CH-1:0]      cur_entry,
    output rom_entry_t [NUM_CH-1:0]      nxt_entry
);

    // Tables are laid out in 8-entry half-beat slots; lead=0 marks a slot continuing a one-beat note.
    function automatic rom_entry_t lookup(input logic [SEL_W-1:0] s, input int ch,
                                          input logic [BEAT_W-1:0] idx);
        rom_entry_t e;
        logic [6:0] pos;
        logic       lead;
        pos     = 7'(idx % BEAT_W'(128));
        e.freq  = SIL;
        e.onset = 1'b0;
        lead    = 1'b1;
        if (int'(idx) < SONG_LEN && int'(s) < NUM_SONGS) begin
            if (s == SEL_W'(0) && ch == 0) begin
                case (pos[6:3])
                    4'd0, 4'd12, 4'd13, 4'd14: e.freq = G4;
                    4'd15:                     begin e.freq = G4; lead = 1'b0; end
                    4'd1, 4'd2, 4'd10:         e.freq = E4;
                    4'd3:                      begin e.freq = E4; lead = 1'b0; end
                    4'd4, 4'd11:               e.freq = F4;
                    4'd5, 4'd6, 4'd9:          e.freq = D4;
                    4'd7:                      begin e.freq = D4; lead = 1'b0; end
                    default:                   e.freq = C4;
                endcase
                e.onset = lead && (pos[2:0] == 3'd0);
            end else if (s == SEL_W'(0) && ch == 1) begin
                case (pos[6:4])
                    3'd1, 3'd4, 3'd7: e.freq = G4;
                    3'd2, 3'd5:       e.freq = B4;
                    default:          e.freq = C4;
                endcase
                e.onset = (pos[3:0] == 4'd0);
            end else if (s == SEL_W'(1) && ch == 0) begin
                case (pos[6:3])
                    4'd0, 4'd4, 4'd5, 4'd6, 4'd10, 4'd13: e.freq = E3;
                    4'd1, 4'd3, 4'd7, 4'd8, 4'd9, 4'd14:  e.freq = D3;
                    4'd11, 4'd12:                         e.freq = G3;
                    default:                              e.freq = C3;
                endcase
                e.onset = (pos[2:0] == 3'd0);
            end else if (s == SEL_W'(1) && ch == 1) begin
                e.freq  = C3;
                e.onset = (pos[4:0] == 5'd0);
            end
        end
        return e;
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cur_entry[c] = lookup(song, c, cur_idx);
            nxt_entry[c] = lookup(song, c, nxt_idx);
        end
    end

endmodule

// File: rtl/music_player.sv
// rtl/music_player.sv - multi-channel tune sequencer with tempo divider and articulation gaps
module music_player
    import music_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int BEAT_W    = 12,
    parameter int SONG_LEN  = 128,
    parameter int NUM_SONGS = 2,
    parameter int DIV_W     = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         stop,
    input  logic                         loop_en,
    input  logic [$clog2(NUM_SONGS)-1:0] song_sel,
    input  logic [DIV_W-1:0]             tempo_div,
    output logic [NUM_CH*32-1:0]         tone,
    output logic [3:0]                   cur_note,
    output logic [BEAT_W-1:0]            beat_num,
    output logic                         playing,
    output logic                         done
);

    localparam int SEL_W = $clog2(NUM_SONGS);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(SONG_LEN - 1);

    state_t                  state, state_next;
    logic [BEAT_W-1:0]       beat_next, nxt_idx;
    logic [DIV_W-1:0]        tick_cnt, tick_cnt_next, term_last;
    logic [SEL_W-1:0]        song_q;
    logic                    loop_q, latch, done_next, tick, has_next;
    logic [NUM_CH*32-1:0]    tone_next;
    rom_entry_t [NUM_CH-1:0] cur_entry, nxt_entry;

    assign term_last = (tempo_div == '0) ? '0 : tempo_div - DIV_W'(1);
    assign tick      = (tick_cnt >= term_last);
    assign nxt_idx   = (beat_num == LAST) ? '0 : beat_num + BEAT_W'(1);
    assign has_next  = (beat_num != LAST) || loop_q;

    music_song_rom #(
        .NUM_CH    (NUM_CH),
        .SONG_LEN  (SONG_LEN),
        .NUM_SONGS (NUM_SONGS),
        .BEAT_W    (BEAT_W),
        .SEL_W     (SEL_W)
    ) u_rom (
        .song      (song_q),
        .cur_idx   (beat_num),
        .nxt_idx   (nxt_idx),
        .cur_entry (cur_entry),
        .nxt_entry (nxt_entry)
    );

    function automatic logic [31:0] articulate(input rom_entry_t cur, input rom_entry_t nxt,
                                               input logic nxt_ok);
        return (nxt_ok && nxt.onset && nxt.freq == cur.freq) ? SIL : cur.freq;
    endfunction

    always_comb begin
        state_next    = state;
        beat_next     = beat_num;
        tick_cnt_next = tick_cnt;
        done_next     = 1'b0;
        latch         = 1'b0;
        if (stop) begin
            state_next    = IDLE;
            beat_next     = '0;
            tick_cnt_next = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_next    = PLAY;
                    latch         = 1'b1;
                    beat_next     = '0;
                    tick_cnt_next = '0;
                end
                PLAY: if (pause) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    tick_cnt_next = '0;
                    if (beat_num < LAST) begin
                        beat_next = beat_num + BEAT_W'(1);
                    end else begin
                        beat_next = '0;
                        if (!loop_q) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end else begin
                    tick_cnt_next = tick_cnt + DIV_W'(1);
                end
                PAUSE: if (!pause) state_next = PLAY;
                default: state_next = IDLE;
            endcase
        end
    end

    // Tones only sound while playback continues through this edge, so leaving PLAY silences at once.
    always_comb begin
        tone_next = {NUM_CH{SIL}};
        if (state == PLAY && state_next == PLAY) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tone_next[32*c +: 32] = articulate(cur_entry[c], nxt_entry[c], has_next);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_num <= '0;
            tick_cnt <= '0;
            song_q   <= '0;
            loop_q   <= 1'b0;
            done     <= 1'b0;
            tone     <= {NUM_CH{SIL}};
        end else begin
            state    <= state_next;
            beat_num <= beat_next;
            tick_cnt <= tick_cnt_next;
            done     <= done_next;
            tone     <= tone_next;
            if (latch) begin
                song_q <= song_sel;
                loop_q <= loop_en;
            end
        end
    end

    assign playing  = (state == PLAY);
    assign cur_note = freq_to_note(tone[31:0]);

endmodule

// File: tb/tb_music_player.sv
// tb/tb_music_player.sv - randomized bench for music_player against a note-list reference model
module tb_music_player;

    localparam int NUM_CH   = 2;
    localparam int BEAT_W   = 12;
    localparam int SONG_LEN = 128;
    localparam int DIV_W    = 24;
    localparam int SILF     = 50_000_000;
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2;

    logic                 clk = 1'b0, rst_n = 1'b0;
    logic                 start = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [0:0]           song_sel = 1'b0;
    logic [DIV_W-1:0]     tempo_div = DIV_W'(4);
    logic [NUM_CH*32-1:0] tone;
    logic [3:0]           cur_note;
    logic [BEAT_W-1:0]    beat_num;
    logic                 playing, done;

    int checks = 0, errors = 0;

    music_player dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .loop_en(loop_en), .song_sel(song_sel), .tempo_div(tempo_div),
        .tone(tone), .cur_note(cur_note), .beat_num(beat_num),
        .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    int s_freq [2][2][SONG_LEN];
    bit s_on   [2][2][SONG_LEN];
    int fill_pos;
    int mel0_f [13] = '{784, 660, 660, 698, 588, 588, 524, 588, 660, 698, 784, 784, 784};
    int mel0_l [13] = '{8, 8, 16, 8, 8, 16, 8, 8, 8, 8, 8, 8, 16};
    int bass_f [3]  = '{524, 784, 988};
    int mel1_f [16] = '{330, 294, 262, 294, 330, 330, 330, 294, 294, 294, 330, 392, 392, 330, 294, 262};
    int scale_hi [7] = '{524, 588, 660, 698, 784, 880, 988};
    int scale_lo [7] = '{262, 294, 330, 349, 392, 440, 494};

    int m_mode, m_beat, m_cnt, m_song;
    bit m_loop, m_done;
    int m_tone [NUM_CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_note(input int s, input int c, input int f, input int len);
        for (int i = 0; i < len; i++) begin
            s_freq[s][c][fill_pos + i] = f;
            s_on[s][c][fill_pos + i]   = (i == 0);
        end
        fill_pos += len;
    endtask

    function automatic int exp_note(input int f);
        for (int i = 0; i < 7; i++) if (f == scale_hi[i] || f == scale_lo[i]) return i + 1;
        return 10;
    endfunction

    function automatic int sounding(input int c);
        int f, ni;
        f  = s_freq[m_song][c][m_beat];
        ni = (m_beat + 1) % SONG_LEN;
        if ((m_beat < SONG_LEN - 1 || m_loop) && s_on[m_song][c][ni] && s_freq[m_song][c][ni] == f)
            return SILF;
        return f;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_beat = 0; m_cnt = 0; m_song = 0; m_loop = 0; m_done = 0;
        for (int c = 0; c < NUM_CH; c++) m_tone[c] = SILF;
    endtask

    task automatic model_step();
        int nm, nb, nc, entry_len;
        bit nd;
        nm = m_mode; nb = m_beat; nc = m_cnt; nd = 0;
        entry_len = (tempo_div == 0) ? 1 : int'(tempo_div);
        if (stop) begin
            nm = M_IDLE; nb = 0; nc = 0;
        end else if (m_mode == M_IDLE) begin
            if (start) begin
                nm = M_PLAY; nb = 0; nc = 0; m_song = int'(song_sel); m_loop = loop_en;
            end
        end else if (m_mode == M_PAUSE) begin
            if (!pause) nm = M_PLAY;
        end else if (pause) begin
            nm = M_PAUSE;
        end else if (m_cnt + 1 >= entry_len) begin
            nc = 0;
            if (m_beat < SONG_LEN - 1) nb = m_beat + 1;
            else if (m_loop) nb = 0;
            else begin nb = 0; nm = M_IDLE; nd = 1; end
        end else begin
            nc = m_cnt + 1;
        end
        for (int c = 0; c < NUM_CH; c++)
            m_tone[c] = (m_mode == M_PLAY && nm == M_PLAY) ? sounding(c) : SILF;
        m_mode = nm; m_beat = nb; m_cnt = nc; m_done = nd;
    endtask

    task automatic compare();
        check("beat_num", 64'(beat_num), 64'(m_beat));
        check("playing", 64'(playing), 64'(m_mode == M_PLAY));
        check("done", 64'(done), 64'(m_done));
        for (int c = 0; c < NUM_CH; c++) check("tone", 64'(tone[32*c +: 32]), 64'(m_tone[c]));
        check("cur_note", 64'(cur_note), 64'(exp_note(m_tone[0])));
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run_until(input int b, input int c, input int budget);
        int n = 0;
        while (!(m_mode == M_PLAY && m_beat == b && m_cnt == c) && n < budget) begin
            step();
            n++;
        end
        check("reach_beat", 64'(beat_num), 64'(b));
    endtask

    task automatic silent_idle(input string tag);
        check({tag, "_tone"}, 64'(tone), {2{32'd50_000_000}});
        check({tag, "_beat"}, 64'(beat_num), 64'd0);
        check({tag, "_playing"}, 64'(playing), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        fill_pos = 0;
        for (int i = 0; i < 13; i++) add_note(0, 0, mel0_f[i], mel0_l[i]);
        fill_pos = 0;
        for (int i = 0; i < 8; i++) add_note(0, 1, bass_f[i % 3], 16);
        fill_pos = 0;
        for (int i = 0; i < 16; i++) add_note(1, 0, mel1_f[i], 8);
        fill_pos = 0;
        for (int i = 0; i < 4; i++) add_note(1, 1, 262, 32);

        model_reset();
        @(negedge clk);
        compare();
        silent_idle("reset");
        check("reset_note", 64'(cur_note), 64'd10);
        rst_n = 1'b1;

        start = 1'b1; song_sel = 1'b0; loop_en = 1'b0; tempo_div = DIV_W'(4);
        step();
        start = 1'b0;
        check("enter_play", 64'(playing), 64'd1);
        step();
        check("beat0_tone", 64'(tone), {32'd524, 32'd784});
        check("beat0_note", 64'(cur_note), 64'd5);

        run_until(10, 2, 200);
        pause = 1'b1;
        repeat (20) step();
        check("pause_beat", 64'(beat_num), 64'd10);
        check("pause_tone", 64'(tone), {2{32'd50_000_000}});
        pause = 1'b0;
        n = 0;
        while (m_mode != M_PLAY && n < 10) begin step(); n++; end
        n = 0;
        while (beat_num != BEAT_W'(11) && n < 10) begin step(); n++; end
        check("pause_resume_cycles", 64'(n), 64'd2);

        run_until(15, 1, 200);
        check("artic_gap", 64'(tone[31:0]), 64'd50_000_000);
        run_until(16, 1, 200);
        check("artic_after", 64'(tone[31:0]), 64'd660);

        n = 0;
        while (!m_done && n < 1000) begin step(); n++; end
        check("done_pulse", 64'(done), 64'd1);
        check("done_beat", 64'(beat_num), 64'd0);
        check("done_idle", 64'(playing), 64'd0);
        step();
        check("done_one_cycle", 64'(done), 64'd0);

        start = 1'b1; loop_en = 1'b1; tempo_div = '0;
        step();
        start = 1'b0; loop_en = 1'b0;
        run_until(127, 0, 400);
        step();
        check("loop_wrap_beat", 64'(beat_num), 64'd0);
        check("loop_playing", 64'(playing), 64'd1);
        check("loop_no_done", 64'(done), 64'd0);
        check("loop_gap", 64'(tone[31:0]), 64'd50_000_000);
        step();

        run_until(50, 0, 400);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        silent_idle("stop_start");
        step();

        start = 1'b1; song_sel = 1'b1; tempo_div = DIV_W'(3);
        step();
        start = 1'b0;
        run_until(30, 1, 400);
        #2 rst_n = 1'b0;
        #1;
        silent_idle("async_reset");
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;

        for (int ep = 0; ep < 6; ep++) begin
            tempo_div = DIV_W'($urandom_range(0, 3));
            for (int k = 0; k < 600; k++) begin
                start    = ($urandom_range(0, 3) == 0);
                stop     = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 24) == 0) pause = ~pause;
                loop_en  = 1'($urandom_range(0, 1));
                song_sel = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 199) == 0) tempo_div = DIV_W'($urandom_range(0, 3));
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
